// File: rtl/line_sync_ctrl.sv
// -----------------------------------------------------------------------------
// line_sync_ctrl
//
// Aligns the show-ahead (FWFT) receive pixel FIFO with the display raster.
// During horizontal blanking of the line before each active line, the FIFO
// head's y_count is compared against the line about to be shown. Stale words
// are popped, a match arms streaming for the coming line, and anything else
// (future data, empty FIFO, drop overrun) shows the line as blank so display
// timing never waits on network data.
//
// FIFO word layout: {x_count[1:0], y_count[10:0], C[7:0], Y[7:0]}
//
// Ports
//   i_clk_74M     pixel clock
//   i_rst         synchronous active-high reset
//   i_vcnt        vertical counter from the timing generator
//   i_hcnt        horizontal counter from the timing generator
//   i_pix_req     pixel read request (high during active pixels)
//   i_fifo_empty  FIFO empty
//   i_fifo_dout   FIFO head word, valid when !i_fifo_empty
//   o_fifo_rd     FIFO pop strobe
//   o_data        pixel word to the data controller (zero-latency mux)
//   o_locked      last checked line matched
//   o_drop_cnt    stale words discarded, saturating
//   o_miss_cnt    lines shown blank (miss or underflow), saturating
// -----------------------------------------------------------------------------
module line_sync_ctrl #(
  parameter logic [11:0] VSTART     = 12'd24,
  parameter logic [11:0] VFIN       = 12'd745,
  parameter logic [11:0] CHK_H      = 12'd1290,
  parameter logic [28:0] BLANK_WORD = 29'h0000_8000
) (
  input  logic        i_clk_74M,
  input  logic        i_rst,
  input  logic [11:0] i_vcnt,
  input  logic [11:0] i_hcnt,
  input  logic        i_pix_req,
  input  logic        i_fifo_empty,
  input  logic [28:0] i_fifo_dout,
  output logic        o_fifo_rd,
  output logic [28:0] o_data,
  output logic        o_locked,
  output logic [15:0] o_drop_cnt,
  output logic [15:0] o_miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_DROP,
    S_ARMED,
    S_STREAM,
    S_MISS
  } state_t;

  state_t      state_q,    state_d;
  logic [10:0] target_q,   target_d;
  logic        locked_q,   locked_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic        uflow_q,    uflow_d;
  logic        pix_req_q,  pix_req_d;

  // ---------------------------------------------------------------------------
  // Raster and FIFO-head decode
  // ---------------------------------------------------------------------------
  logic [11:0] nxt;
  logic [10:0] nxt_target;
  logic [10:0] head_y;
  logic        check_fire;
  logic        head_stale;
  logic        pix_fall;
  logic        drop_pop;

  assign nxt        = i_vcnt + 12'd1;
  // Only the low 11 bits of the line index are carried in y_count.
  assign nxt_target = nxt[10:0] - VSTART[10:0];
  assign head_y     = i_fifo_dout[26:16];
  assign check_fire = (i_hcnt == CHK_H) && (nxt >= VSTART) && (nxt < VFIN);
  // Unsigned compare: after a y_count wrap the old frame's tail reads as
  // stale and is flushed rather than held as future data.
  assign head_stale = !i_fifo_empty && (head_y < target_q);
  assign pix_fall   = pix_req_q && !i_pix_req;
  // Dropping must not spill into the active line: hcnt==0 aborts to MISS.
  assign drop_pop   = (state_q == S_DROP) && head_stale && (i_hcnt != 12'd0);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic enter_miss;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can
    // leave it unassigned; a missing default here would infer a latch.
    state_d    = state_q;
    target_d   = target_q;
    locked_d   = locked_q;
    drop_cnt_d = drop_cnt_q;
    miss_cnt_d = miss_cnt_q;
    uflow_d    = uflow_q;
    pix_req_d  = i_pix_req;
    enter_miss = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (check_fire) begin
          target_d = nxt_target;
          state_d  = S_CHECK;
        end
      end

      S_CHECK: begin
        if (i_fifo_empty) begin
          enter_miss = 1'b1;
        end else if (head_y < target_q) begin
          state_d = S_DROP;
        end else if (head_y == target_q) begin
          state_d  = S_ARMED;
          locked_d = 1'b1;
        end else begin
          // Future data: the head word stays for its own line.
          enter_miss = 1'b1;
        end
      end

      S_DROP: begin
        if (i_hcnt == 12'd0) begin
          enter_miss = 1'b1;
        end else if (head_stale) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
        end else begin
          // Re-evaluate the new head with a fresh CHECK cycle.
          state_d = S_CHECK;
        end
      end

      S_ARMED: begin
        locked_d = 1'b1;
        // The first request cycle only hands over to STREAM; reads start
        // on the following cycle.
        if (i_pix_req) begin
          state_d = S_STREAM;
        end
      end

      S_STREAM: begin
        if (i_pix_req && i_fifo_empty) begin
          uflow_d = 1'b1;
        end
        if (pix_fall) begin
          state_d = S_IDLE;
          if (uflow_q) begin
            miss_cnt_d = sat_inc(miss_cnt_q);
            locked_d   = 1'b0;
            uflow_d    = 1'b0;
          end
        end
      end

      S_MISS: begin
        // A new check outranks the end of the blank line.
        if (check_fire) begin
          target_d = nxt_target;
          state_d  = S_CHECK;
        end else if (pix_fall) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (enter_miss) begin
      state_d    = S_MISS;
      locked_d   = 1'b0;
      miss_cnt_d = sat_inc(miss_cnt_q);
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk_74M) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      target_q   <= '0;
      locked_q   <= 1'b0;
      drop_cnt_q <= '0;
      miss_cnt_q <= '0;
      uflow_q    <= 1'b0;
      pix_req_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      target_q   <= target_d;
      locked_q   <= locked_d;
      drop_cnt_q <= drop_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      uflow_q    <= uflow_d;
      pix_req_q  <= pix_req_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    o_fifo_rd = 1'b0;
    if (!i_rst) begin
      unique case (state_q)
        S_DROP:   o_fifo_rd = drop_pop;
        S_STREAM: o_fifo_rd = i_pix_req && !i_fifo_empty;
        default:  o_fifo_rd = 1'b0;
      endcase
    end
  end

  // Zero-latency path from the FIFO head; read-to-advance follows FWFT timing.
  assign o_data = ((state_q == S_STREAM) && !i_fifo_empty) ? i_fifo_dout : BLANK_WORD;

  assign o_locked   = locked_q;
  assign o_drop_cnt = drop_cnt_q;
  assign o_miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_line_sync_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_sync_ctrl
//
// Directed bench for line_sync_ctrl. A behavioural FWFT FIFO feeds the DUT;
// the raster counters and pixel request are driven directly step by step.
// Expected values are hand-derived from the raster arithmetic:
//   target = vcnt + 1 - 24 (low 11 bits), check at hcnt 1290, line wraps
//   after hcnt 1649, so a drop started at 1290 pops at hcnt 1292..1649.
// -----------------------------------------------------------------------------
module tb_line_sync_ctrl;

  localparam logic [28:0] BLANK = 29'h0000_8000;
  localparam logic [11:0] CHK_H = 12'd1290;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [11:0] i_vcnt;
  logic [11:0] i_hcnt;
  logic        i_pix_req;
  logic        fifo_empty;
  logic [28:0] fifo_dout;
  logic        o_fifo_rd;
  logic [28:0] o_data;
  logic        o_locked;
  logic [15:0] o_drop_cnt;
  logic [15:0] o_miss_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Behavioural show-ahead FIFO
  logic [28:0] fifo_mem [0:4095];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_dout  = fifo_mem[rd_ptr[11:0]];

  always @(posedge clk) begin
    if (o_fifo_rd && !fifo_empty) rd_ptr <= rd_ptr + 1;
  end

  line_sync_ctrl dut (
    .i_clk_74M    (clk),
    .i_rst        (i_rst),
    .i_vcnt       (i_vcnt),
    .i_hcnt       (i_hcnt),
    .i_pix_req    (i_pix_req),
    .i_fifo_empty (fifo_empty),
    .i_fifo_dout  (fifo_dout),
    .o_fifo_rd    (o_fifo_rd),
    .o_data       (o_data),
    .o_locked     (o_locked),
    .o_drop_cnt   (o_drop_cnt),
    .o_miss_cnt   (o_miss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [28:0] word(input int idx, input logic [10:0] y);
    logic [1:0] x;
    logic [7:0] c;
    logic [7:0] yy;
    x  = idx[1:0];
    c  = 8'(idx * 5 + 1);
    yy = 8'(idx);
    return {x, y, c, yy};
  endfunction

  task automatic push(input int n, input logic [10:0] y);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr[11:0]] = word(i, y);
      wr_ptr++;
    end
  endtask

  function automatic int level();
    return int'(wr_ptr - rd_ptr);
  endfunction

  // Check cycle at hcnt 1290 on line v, then one more blanking cycle so the
  // CHECK decision has been taken when this returns.
  task automatic arm(input logic [11:0] v);
    i_vcnt = v;
    i_hcnt = CHK_H;
    cyc();
    i_hcnt = CHK_H + 12'd1;
    cyc();
  endtask

  // n_total request cycles in STREAM; the first n_data expect FIFO words
  // word(i, y) with a pop, the rest expect BLANK with no pop.
  task automatic stream_px(input int n_data, input int n_total, input logic [10:0] y,
                           output int errs, output int pops);
    logic [28:0] exp_w;
    errs = 0;
    pops = 0;
    for (int i = 0; i < n_total; i++) begin
      exp_w = (i < n_data) ? word(i, y) : BLANK;
      if (o_data !== exp_w || o_fifo_rd !== (i < n_data)) errs++;
      if (o_fifo_rd) pops++;
      cyc();
    end
  endtask

  // Horizontal blanking from the check point to the wrap; returns pop count.
  task automatic run_blank(input logic [11:0] v, output int pops);
    pops   = 0;
    i_vcnt = v;
    for (int h = 1290; h < 1650; h++) begin
      i_hcnt = 12'(h);
      #1;
      if (o_fifo_rd) pops++;
      cyc();
    end
    i_hcnt = 12'd0;
    #1;
    if (o_fifo_rd) pops++;
    cyc();
    i_hcnt = 12'd1;
  endtask

  initial begin
    int       errs;
    int       pops;
    logic [6:0] pat;

    i_rst     = 1'b1;
    i_vcnt    = 12'd0;
    i_hcnt    = 12'd0;
    i_pix_req = 1'b0;
    cyc();
    cyc();

    // Reset state
    check("rst_rd",     32'(o_fifo_rd),  32'd0);
    check("rst_locked", 32'(o_locked),   32'd0);
    check("rst_drop",   32'(o_drop_cnt), 32'd0);
    check("rst_miss",   32'(o_miss_cnt), 32'd0);
    check("rst_data",   32'(o_data),     32'(BLANK));
    i_rst = 1'b0;
    cyc();

    // Matched stream: line 0, check at vcnt 23
    push(1280, 11'd0);
    arm(12'd23);
    check("t1_locked", 32'(o_locked),  32'd1);
    check("t1_rd_arm", 32'(o_fifo_rd), 32'd0);
    i_hcnt    = 12'd0;
    i_pix_req = 1'b1;
    cyc();
    stream_px(1280, 1280, 11'd0, errs, pops);
    check("t1_data", 32'(errs), 32'd0);
    check("t1_pops", 32'(pops), 32'd1280);
    i_pix_req = 1'b0;
    cyc();
    check("t1_drop",   32'(o_drop_cnt), 32'd0);
    check("t1_miss",   32'(o_miss_cnt), 32'd0);
    check("t1_locked_end", 32'(o_locked), 32'd1);

    // Stale drop: 5 words of line 3 ahead of line 7, target 7 (vcnt 30)
    push(5, 11'd3);
    push(8, 11'd7);
    arm(12'd30);
    pat = '0;
    for (int k = 0; k < 7; k++) begin
      pat[k] = o_fifo_rd;
      cyc();
    end
    check("t2_rd_pattern", 32'(pat),        32'h1F);
    check("t2_drop",       32'(o_drop_cnt), 32'd5);
    check("t2_locked",     32'(o_locked),   32'd1);
    i_hcnt    = 12'd0;
    i_pix_req = 1'b1;
    cyc();
    stream_px(8, 8, 11'd7, errs, pops);
    check("t2_data", 32'(errs), 32'd0);
    check("t2_pops", 32'(pops), 32'd8);
    i_pix_req = 1'b0;
    cyc();

    // Future data: head y=10, target 8 (vcnt 31)
    push(3, 11'd10);
    arm(12'd31);
    check("t3_miss1",  32'(o_miss_cnt), 32'd1);
    check("t3_locked", 32'(o_locked),   32'd0);
    i_hcnt    = 12'd0;
    i_pix_req = 1'b1;
    stream_px(0, 20, 11'd10, errs, pops);
    check("t3_blank", 32'(errs), 32'd0);
    i_pix_req = 1'b0;
    cyc();
    check("t3_head_kept", 32'(level()), 32'd3);
    arm(12'd32);
    check("t3_miss2", 32'(o_miss_cnt), 32'd2);
    // Check fires while still in MISS: target 10 now matches
    arm(12'd33);
    check("t3_prio_locked", 32'(o_locked),   32'd1);
    check("t3_prio_miss",   32'(o_miss_cnt), 32'd2);
    i_hcnt    = 12'd0;
    i_pix_req = 1'b1;
    cyc();
    stream_px(3, 3, 11'd10, errs, pops);
    check("t3_data", 32'(errs), 32'd0);
    i_pix_req = 1'b0;
    cyc();

    // Underflow: 600 words of line 11, target 11 (vcnt 34)
    push(600, 11'd11);
    arm(12'd34);
    check("t4_locked", 32'(o_locked), 32'd1);
    i_hcnt    = 12'd0;
    i_pix_req = 1'b1;
    cyc();
    stream_px(600, 1280, 11'd11, errs, pops);
    check("t4_data",     32'(errs), 32'd0);
    check("t4_pops",     32'(pops), 32'd600);
    check("t4_miss_mid", 32'(o_miss_cnt), 32'd2);
    i_pix_req = 1'b0;
    cyc();
    check("t4_miss",   32'(o_miss_cnt), 32'd3);
    check("t4_locked_end", 32'(o_locked), 32'd0);

    // Drop overrun: 2000 stale words of line 12, then line 18.
    // Each blanking window pops 358 before the wrap aborts to MISS.
    push(2000, 11'd12);
    push(400, 11'd18);
    for (int a = 0; a < 5; a++) begin
      run_blank(12'(36 + a), pops);
      check($sformatf("t5_pops_%0d", a),   32'(pops),       32'd358);
      check($sformatf("t5_locked_%0d", a), 32'(o_locked),   32'd0);
      check($sformatf("t5_miss_%0d", a),   32'(o_miss_cnt), 32'(4 + a));
    end
    run_blank(12'd41, pops);
    check("t5_pops_last", 32'(pops),       32'd210);
    check("t5_locked",    32'(o_locked),   32'd1);
    check("t5_drop",      32'(o_drop_cnt), 32'd2005);
    check("t5_miss",      32'(o_miss_cnt), 32'd8);

    // Reset at pixel 300 of a streamed line
    i_hcnt    = 12'd0;
    i_pix_req = 1'b1;
    cyc();
    stream_px(299, 299, 11'd18, errs, pops);
    check("t6_data", 32'(errs), 32'd0);
    check("t6_pops", 32'(pops), 32'd299);
    i_rst = 1'b1;
    #1;
    check("t6_rd_in_rst", 32'(o_fifo_rd), 32'd0);
    cyc();
    i_rst = 1'b0;
    #1;
    check("t6_data_rst", 32'(o_data),     32'(BLANK));
    check("t6_locked",   32'(o_locked),   32'd0);
    check("t6_drop",     32'(o_drop_cnt), 32'd0);
    check("t6_miss",     32'(o_miss_cnt), 32'd0);
    check("t6_rd_idle",  32'(o_fifo_rd),  32'd0);
    i_pix_req = 1'b0;
    cyc();
    check("t6_level", 32'(level()), 32'd101);

    // Region boundaries: head y=721 matches vcnt 744 if a check wrongly fired
    wr_ptr = rd_ptr;
    push(1, 11'd721);
    arm(12'd744);
    cyc();
    check("t7_no_chk_hi_locked", 32'(o_locked),   32'd0);
    check("t7_no_chk_hi_miss",   32'(o_miss_cnt), 32'd0);
    arm(12'd743);
    check("t7_last_line_miss", 32'(o_miss_cnt), 32'd1);
    check("t7_head_kept",      32'(level()),    32'd1);
    arm(12'd22);
    cyc();
    check("t7_no_chk_lo_drop", 32'(o_drop_cnt), 32'd0);
    check("t7_no_chk_lo_miss", 32'(o_miss_cnt), 32'd1);
    check("t7_no_chk_lo_lvl",  32'(level()),    32'd1);
    arm(12'd23);
    check("t7_first_line_miss", 32'(o_miss_cnt), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/line_sync_ctrl.md
Name: line_sync_ctrl

Overview:
- Sits between the show-ahead (FWFT) receive pixel FIFO and the pixel-clock YCbCr→RGB data controller.
- Each FIFO word is 29 bits: {x_count[1:0], y_count[10:0], C[7:0], Y[7:0]}.
- Before each active display line, the block checks the FIFO head's y_count against the line about to be shown, discards stale words, and arms streaming only on a match.
- Lines with no matching data are filled with a blank word, so display timing never stalls on network data.

Parameters:
VSTART, 12'd24, first active vcnt.
VFIN, 12'd745, first vcnt after the active region.
CHK_H, 12'd1290, hcnt in horizontal blanking at which the next line is checked.
BLANK_WORD, 29'h0000_8000, word presented on unmatched/underflow pixels (Y=0, C=0x80).

Ports:
i_clk_74M  in  1  74.25 MHz pixel clock
i_rst  in  1  synchronous active-high reset
i_vcnt  in  12  vertical counter from the timing generator
i_hcnt  in  12  horizontal counter from the timing generator
i_pix_req  in  1  pixel read request from the data controller (high during active pixels)
i_fifo_empty  in  1  FIFO empty
i_fifo_dout  in  29  FIFO head word, valid when !i_fifo_empty
o_fifo_rd  out  1  FIFO pop strobe
o_data  out  29  pixel word to the data controller
o_locked  out  1  last checked line matched
o_drop_cnt  out  16  stale words discarded, saturating
o_miss_cnt  out  16  lines shown blank (miss or underflow), saturating

Behaviour:
- Clock and reset: one clock, i_clk_74M. Reset i_rst is synchronous, active-high.
- Reset values: state=IDLE, o_locked=0, both counters 0, o_data=BLANK_WORD. o_fifo_rd is forced 0 in any cycle where i_rst=1.
- Definitions:
  - head_y = i_fifo_dout[26:16].
  - nxt = i_vcnt+1 (12-bit).
  - target = (nxt-VSTART)[10:0], latched at check time.
  - A check fires when i_hcnt==CHK_H and VSTART<=nxt<VFIN.
- IDLE: o_fifo_rd=0, o_data=BLANK_WORD. On a check, latch target → CHECK.
- CHECK: one cycle; decision uses the current head.
  - Empty → MISS.
  - head_y<target (unsigned) → DROP.
  - head_y==target → ARMED.
  - head_y>target → MISS; the head word is kept.
- DROP:
  - o_fifo_rd=1 while !empty and head_y<target. Each pop increments o_drop_cnt (saturates at 16'hFFFF).
  - When the condition fails → CHECK.
  - If i_hcnt==0 arrives first (the line is starting) → MISS.
- ARMED: o_fifo_rd=0; set o_locked=1. The first cycle with i_pix_req=1 → STREAM.
- STREAM:
  - o_fifo_rd = i_pix_req & !i_fifo_empty (combinational).
  - o_data = i_fifo_dout when !empty, else BLANK_WORD. An empty during i_pix_req is an underflow: set an internal underflow flag.
  - On the falling edge of i_pix_req → IDLE. If the underflow flag is set, increment o_miss_cnt once, clear o_locked, and clear the flag.
- MISS:
  - On entry: o_locked=0; o_miss_cnt+1, saturating.
  - No FIFO reads; o_data=BLANK_WORD for the whole line.
  - On the falling edge of i_pix_req → IDLE.
  - If a new check fires while still in MISS → CHECK; the new check takes priority.
- o_data is a combinational mux selected by registered state; latency from i_fifo_dout is zero cycles. The read-to-advance timing is therefore the FIFO's FWFT timing.
- Outside VSTART..VFIN-1 no checks fire, the FSM stays in IDLE, and o_data=BLANK_WORD.
- Comparisons are unsigned: a y_count wrap at frame end (head_y small, target large) drops words until the frame's remaining lines are flushed.
- Simultaneous reset and any event: reset wins.
- Counters never wrap.

Test Plan:
- Matched stream: FIFO holds line 0 with 1280 words (y=0). Check at vcnt=23 → ARMED, o_locked=1. 1280 pops during i_pix_req, o_data equals the FIFO words in order, o_drop_cnt=0.
- Stale drop: FIFO holds 5 words y=3 then a line with y=7. Check with target=7 → exactly 5 consecutive o_fifo_rd pulses, o_drop_cnt=5, then ARMED.
- Future data: head y=10, target=8 → MISS. Line output all 29'h0000_8000, o_miss_cnt=1, head word not popped. Next check with target=9 → MISS again, o_miss_cnt=2.
- Underflow: ARMED with only 600 words queued. Pixels 601..1280 output BLANK_WORD, o_fifo_rd=0 while empty. At line end o_miss_cnt+1, o_locked=0.
- Drop overrun: 2000 stale words queued and check at hcnt=1290 (fewer than 2000 cycles before hcnt wraps to 0). Dropping stops at the wrap, state → MISS, the remaining stale words are dropped at the next check.
- Reset mid-STREAM: assert i_rst at pixel 300. The same cycle o_fifo_rd=0; next cycle all outputs are at reset values and state is IDLE.
